uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART byte transmitter between NUM_REQ requesters.
- Accepts one byte per requester through a valid/ready handshake.
- Presents the accepted byte to the transmitter and asserts its start request.
- Tracks the transmitter's busy flag through the frame, then enforces an inter-frame idle gap before the next grant.
- Sits between client blocks (command responder, status reporter, debug echo) and the UART TX FSM.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
GAP_CYCLES, 16, idle clocks after transmitter busy falls, before the next grant (0 allowed).
START_TIMEOUT, 65535, max clocks o_tx_start may stay high without i_tx_busy rising.
CNT_W, 16, width of gap/timeout counter; must hold max(GAP_CYCLES, START_TIMEOUT).

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_req_valid  input  NUM_REQ  per-requester byte-valid.
i_req_data  input  8*NUM_REQ  packed bytes; requester k at [8k+7:8k].
o_req_ready  output  NUM_REQ  one-hot accept strobe.
o_tx_start  output  1  start request to transmitter.
o_tx_data  output  8  byte to transmitter, held stable from accept until return to IDLE.
i_tx_busy  input  1  transmitter frame in progress.
o_grant_id  output  3  index of last accepted requester.
o_busy  output  1  high in any state other than IDLE.
o_err_timeout  output  1  one-cycle pulse on start timeout.

Behaviour:
- Reset: i_reset sampled on the rising edge of i_clk, synchronous and active-high.
  - Reset values: state=IDLE; o_req_ready=0, o_tx_start=0, o_tx_data=0, o_grant_id=0, o_busy=0, o_err_timeout=0; counter=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts immediately. The transmitter is reset by the same signal.
- States: IDLE, START, DRAIN, GAP.
- IDLE:
  - Winner = first k with i_req_valid[k]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - o_req_ready is combinational: one-hot winner while in IDLE with any valid; else 0. A transfer occurs in the cycle valid&ready are both high.
  - On a transfer: o_tx_data<=winner byte, o_grant_id<=winner, last<=winner, counter<=0, go to START.
  - Valids from other requesters wait; they are never dropped.
- START:
  - o_tx_start=1.
  - If i_tx_busy=1: go to DRAIN.
  - Else if counter==START_TIMEOUT-1: pulse o_err_timeout, go to IDLE; the byte is discarded.
  - Else counter++.
- DRAIN: o_tx_start=0. Wait for i_tx_busy=0, then counter<=0 and go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: counter++. On counter==GAP_CYCLES-1, go to IDLE.
- Latency:
  - Accept edge to o_tx_start high: 1 clock.
  - Busy falling to next possible o_req_ready: GAP_CYCLES+1 clocks.
- Boundaries:
  - i_tx_busy already high at START entry: START lasts exactly 1 cycle.
  - A requester dropping valid before being granted is legal; no state change.
  - Simultaneous valids: strict RR, no requester starves. Worst-case wait is NUM_REQ-1 frames.
  - o_tx_data never changes outside IDLE.
  - o_req_ready is never asserted outside IDLE, including on the timeout cycle.
  - o_grant_id is zero-extended when NUM_REQ<=4.

Test Plan:
1. Reset, then req0 valid with 0x55, model busy rising 3 cycles after start, high 100 cycles -> ready[0] 1 cycle; o_tx_data=0x55; o_tx_start high exactly 4 cycles; o_busy falls GAP_CYCLES+1 clocks after busy falls.
2. All 4 valids held continuously (bytes 0xA0..0xA3) -> grant order 0,1,2,3,0; each o_req_ready single-cycle one-hot; o_tx_data matches the granted byte.
3. START_TIMEOUT=10, busy tied 0, req2 valid -> o_tx_start high 10 cycles; o_err_timeout pulses once; return to IDLE; next grant goes to req3 if valid.
4. GAP_CYCLES=0, busy already high on the start cycle -> START lasts 1 cycle; next ready asserted 1 clock after busy falls.
5. i_reset asserted during DRAIN -> next cycle all outputs 0; state IDLE; RR restarts at requester 0.
6. req1 valid pulses for 1 cycle while the arbiter is in GAP -> no accept; o_tx_data unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between NUM_REQ client blocks. Clients
//   offer one byte each on a valid/ready handshake. A round-robin pick chooses
//   the winner, and its byte is handed to the transmitter with a start request.
//   The arbiter then follows the transmitter busy flag through the frame and
//   holds off the next grant for GAP_CYCLES idle clocks.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset (also resets the transmitter)
//   i_req_valid    per-requester byte valid
//   i_req_data     packed bytes, requester k at [8k+7:8k]
//   o_req_ready    one-hot accept strobe (combinational, IDLE only)
//   o_tx_start     start request to the transmitter
//   o_tx_data      byte to the transmitter, stable outside IDLE
//   i_tx_busy      transmitter frame in progress
//   o_grant_id     index of the last accepted requester (zero-extended)
//   o_busy         high whenever the sequencer is not idle
//   o_err_timeout  one-cycle pulse when the transmitter never acknowledged start
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a valid byte; o_req_ready offered to the RR winner
//   ST_START | o_tx_start high until i_tx_busy rises or the timeout expires
//   ST_DRAIN | frame in flight, waiting for i_tx_busy to fall
//   ST_GAP   | enforced idle time before the next grant

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 65535,
  parameter int CNT_W         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic [2:0]           o_grant_id,
  output logic                 o_busy,
  output logic                 o_err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
  // Only meaningful when GAP_CYCLES > 0; the GAP state is skipped otherwise.
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic [2:0]         grant_q, grant_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [7:0]         win_byte;
  int                 cand;

  // Round-robin search starting just after the last winner. Because the
  // search wraps through every index, the last winner is checked last, so a
  // requester that keeps valid high waits at most NUM_REQ-1 frames.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && i_req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    win_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_byte = i_req_data[8*k +: 8];
      end
    end
  end

  // Ready is held low while reset is asserted, because reset overrides any
  // transfer on that edge and the client must not see its byte as taken.
  always_comb begin
    o_req_ready = '0;
    if ((state_q == ST_IDLE) && win_found && !i_reset) begin
      o_req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    grant_d = grant_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          data_d  = win_byte;
          grant_d = 3'(win_idx);
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (i_tx_busy) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Transmitter never picked the byte up; drop it and report.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (!i_tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    tx_start_d = (state_d == ST_START);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      data_q     <= 8'h00;
      grant_q    <= 3'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_start    = tx_start_q;
  assign o_tx_data     = data_q;
  assign o_grant_id    = grant_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. A driver offers random bytes and plays the
// transmitter; for each frame it pushes the expected grant, byte, start
// length and timeout flag into a queue. A monitor pops and compares whenever
// the DUT raises o_req_ready, and checks frame timing against the pushed
// record. A second instance with GAP_CYCLES=0 gets a short directed sequence.

module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 3;
  localparam int TMO = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            busy;
  logic            err;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_busy(tx_busy), .o_grant_id(grant_id), .o_busy(busy), .o_err_timeout(err)
  );

  logic            z_rst;
  logic [NR-1:0]   z_valid;
  logic [8*NR-1:0] z_data;
  logic [NR-1:0]   z_ready;
  logic            z_start;
  logic [7:0]      z_txd;
  logic            z_busy;
  logic [2:0]      z_gid;
  logic            z_obusy;
  logic            z_err;
  bit              z_done = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .START_TIMEOUT(TMO), .CNT_W(16)) u_dut_gap0 (
    .i_clk(clk), .i_reset(z_rst), .i_req_valid(z_valid), .i_req_data(z_data),
    .o_req_ready(z_ready), .o_tx_start(z_start), .o_tx_data(z_txd),
    .i_tx_busy(z_busy), .o_grant_id(z_gid), .o_busy(z_obusy), .o_err_timeout(z_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending bytes per requester and the last winner.
  typedef struct {
    int id;
    int data;
    int start_len;
    bit tmo;
  } exp_t;

  exp_t exp_q[$];
  bit   pend[NR];
  int   pbyte[NR];
  int   last_m;

  function automatic int rr_pick();
    for (int i = 1; i <= NR; i++) begin
      if (pend[(last_m + i) % NR]) return (last_m + i) % NR;
    end
    return -1;
  endfunction

  task automatic add_reqs();
    int any;
    any = 0;
    for (int k = 0; k < NR; k++) begin
      if (pend[k] && $urandom_range(7) == 0) begin
        pend[k] = 1'b0;
        req_valid[k] = 1'b0;
      end else if (!pend[k] && $urandom_range(1) == 1) begin
        pend[k] = 1'b1;
        pbyte[k] = int'($urandom_range(255));
        req_data[8*k +: 8] = 8'(pbyte[k]);
        req_valid[k] = 1'b1;
      end
      if (pend[k]) any++;
    end
    if (any == 0) begin
      int k;
      k = int'($urandom_range(NR - 1));
      pend[k] = 1'b1;
      pbyte[k] = int'($urandom_range(255));
      req_data[8*k +: 8] = 8'(pbyte[k]);
      req_valid[k] = 1'b1;
    end
  endtask

  task automatic set_req(input int k, input int b);
    pend[k] = 1'b1;
    pbyte[k] = b;
    req_data[8*k +: 8] = 8'(b);
    req_valid[k] = 1'b1;
  endtask

  task automatic give_up(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench aborted");
  endtask

  // One frame: push expectation, wait for the accept, then act as the
  // transmitter (busy rises d cycles after start and stays high len cycles,
  // or never rises for a timeout frame).
  task automatic do_frame(input int d, input int len, input bit tmo);
    exp_t e;
    int   w;
    int   waited;
    int   p;
    w = rr_pick();
    e.id        = w;
    e.data      = pbyte[w];
    e.start_len = tmo ? TMO : d + 1;
    e.tmo       = tmo;
    exp_q.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready == '0 && waited < 200);
    if (req_ready == '0) give_up("wait_ready");
    @(posedge clk); #1;
    pend[w] = 1'b0;
    req_valid[w] = 1'b0;
    last_m = w;
    if (!tmo) begin
      repeat (d) begin @(posedge clk); #1; end
      tx_busy = 1'b1;
      repeat (len) begin @(posedge clk); #1; end
      tx_busy = 1'b0;
      @(posedge clk); #1;
      // A one-cycle valid from an idle requester during the gap must be ignored.
      p = int'($urandom_range(NR - 1));
      if (!pend[p]) begin
        req_data[8*p +: 8] = 8'($urandom_range(255));
        req_valid[p] = 1'b1;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
      end
    end
  endtask

  // Monitor
  bit   mon_en = 1'b0;
  exp_t cur = '{id: 0, data: 0, start_len: 0, tmo: 1'b0};
  int   cyc = 0;
  int   start_cnt = 0;
  int   fall_cyc = 0;
  bit   start_prev = 1'b0;
  bit   busy_prev = 1'b0;
  bit   txbusy_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      check_eq("err_pulse", int'(err), (start_prev && !tx_start && cur.tmo) ? 1 : 0);
      if (tx_start) start_cnt++;
      if (start_prev && !tx_start) check_eq("start_len", start_cnt, cur.start_len);
      if (txbusy_prev && !tx_busy) fall_cyc = cyc;
      if (busy_prev && !busy) begin
        if (cur.tmo) check_eq("tmo_to_idle", int'(start_prev), 1);
        else         check_eq("gap_len", cyc - fall_cyc, GAP + 1);
      end
      if (busy) begin
        check_eq("ready_outside_idle", int'(req_ready), 0);
        check_eq("tx_data", int'(tx_data), cur.data);
        check_eq("grant_id", int'(grant_id), cur.id);
      end
      if (req_ready != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ready", int'(req_ready), 0);
        end else begin
          cur = exp_q.pop_front();
          check_eq("ready_onehot", int'(req_ready), 1 << cur.id);
          check_eq("ready_when_idle", int'(busy), 0);
          start_cnt = 0;
        end
      end
      start_prev  = tx_start;
      busy_prev   = busy;
      txbusy_prev = tx_busy;
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, int'(req_ready), 0);
    check_eq({tag, "_start"}, int'(tx_start), 0);
    check_eq({tag, "_data"},  int'(tx_data), 0);
    check_eq({tag, "_gid"},   int'(grant_id), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
    check_eq({tag, "_err"},   int'(err), 0);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_busy = 1'b0;
    last_m = NR - 1;
    for (int k = 0; k < NR; k++) begin
      pend[k] = 1'b0;
      pbyte[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single byte from requester 0, busy rises 3 cycles after start.
    set_req(0, 8'h55);
    do_frame(3, 100, 1'b0);

    // All four requesters valid at once.
    for (int k = 0; k < NR; k++) set_req(k, 8'hA0 + k);
    for (int n = 0; n < 4; n++) do_frame(1, 2, 1'b0);
    set_req(last_m, 8'hA0 + last_m);
    do_frame(0, 3, 1'b0);
    for (int k = 0; k < NR; k++) begin
      if (pend[k]) do_frame(2, 1, 1'b0);
    end

    // Timeout on requester 2 alone, then requester 3 should win over 0.
    set_req(2, 8'h7E);
    do_frame(0, 0, 1'b1);
    set_req(3, 8'h33);
    set_req(0, 8'h44);
    do_frame(1, 2, 1'b0);
    if (pend[0]) do_frame(0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      add_reqs();
      if ($urandom_range(5) == 0) do_frame(0, 0, 1'b1);
      else do_frame(int'($urandom_range(3)), int'($urandom_range(6, 1)), 1'b0);
    end

    req_valid = '0;
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (busy && waited < 100);
    if (busy) give_up("drain_idle");
    check_eq("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    mon_en = 1'b0;

    // Reset while the frame is in DRAIN.
    req_data[15:8] = 8'h3C;
    req_valid = 4'b0010;
    @(negedge clk);
    check_eq("rst_pre_ready", int'(req_ready), 4'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    tx_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pre_busy", int'(busy), 1);
    check_eq("rst_pre_start", int'(tx_start), 0);
    check_eq("rst_pre_data", int'(tx_data), 8'h3C);
    @(posedge clk); #1;
    rst = 1'b1;
    tx_busy = 1'b0;
    req_valid = '1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rr_restart", int'(req_ready), 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check_eq("rr_restart_gid", int'(grant_id), 0);

    waited = 0;
    while (!z_done && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    if (!z_done) give_up("gap0_done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // GAP_CYCLES=0 instance: busy already high on the start cycle.
  initial begin
    z_rst = 1'b1;
    z_valid = '0;
    z_data = '0;
    z_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    z_rst = 1'b0;
    z_data[23:16] = 8'h9E;
    z_valid[2] = 1'b1;
    @(negedge clk);
    check_eq("g0_ready", int'(z_ready), 4'b0100);
    @(posedge clk); #1;
    z_valid = '0;
    z_busy = 1'b1;
    @(negedge clk);
    check_eq("g0_start_hi", int'(z_start), 1);
    check_eq("g0_data", int'(z_txd), 8'h9E);
    check_eq("g0_gid", int'(z_gid), 2);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("g0_start_1cyc", int'(z_start), 0);
    check_eq("g0_busy_drain", int'(z_obusy), 1);
    repeat (3) @(posedge clk);
    #1;
    z_data[7:0] = 8'h11;
    z_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("g0_no_ready_drain", int'(z_ready), 0);
    @(posedge clk); #1;
    z_busy = 1'b0;
    @(negedge clk);
    check_eq("g0_no_ready_fall", int'(z_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("g0_ready_next", int'(z_ready), 4'b0001);
    check_eq("g0_idle", int'(z_obusy), 0);
    @(posedge clk); #1;
    z_valid = '0;
    z_done = 1'b1;
  end

endmodule
